// File: rtl/pulse_sequencer_multi.sv
// Multi-sweep one-hot pulse sequencer: programmable per-step durations, an idle gap
// between steps, selectable last step, repeat or loop sweeps, abort, busy/done status.
module pulse_sequencer_multi #(
    parameter int NB_STATE     = 2,
    parameter int N_STEPS      = 8,
    parameter int LOG2_N_STEPS = 3,
    parameter int NB_TIMER     = 8,
    parameter int NB_REPEAT    = 4
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_valid,
    input  logic                        i_trigger,
    input  logic                        i_abort,
    input  logic                        i_loop,
    input  logic [NB_REPEAT-1:0]        i_n_repeat,
    input  logic [LOG2_N_STEPS-1:0]     i_last_step,
    input  logic [N_STEPS*NB_TIMER-1:0] i_limit_time_bus,
    input  logic [NB_TIMER-1:0]         i_gap_time,
    output logic [N_STEPS-1:0]          o_pulse_bus,
    output logic [LOG2_N_STEPS-1:0]     o_step,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [NB_STATE-1:0]         o_state
);

    localparam int N_SLOTS = 1 << LOG2_N_STEPS;

    localparam logic [LOG2_N_STEPS:0]   N_STEPS_EXT = (LOG2_N_STEPS + 1)'(N_STEPS);
    localparam logic [LOG2_N_STEPS-1:0] LAST_MAX    = LOG2_N_STEPS'(N_STEPS - 1);
    localparam logic [LOG2_N_STEPS-1:0] STEP_ONE    = LOG2_N_STEPS'(1);
    localparam logic [NB_TIMER-1:0]     TIMER_ONE   = NB_TIMER'(1);
    localparam logic [NB_REPEAT-1:0]    SWEEP_ONE   = NB_REPEAT'(1);
    localparam logic [N_SLOTS-1:0]      ONEHOT_BASE = N_SLOTS'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ACT_NEXT_STEP  = 2'd0,
        ACT_NEXT_SWEEP = 2'd1,
        ACT_FINISH     = 2'd2
    } step_action_t;

    state_t                  state_q,     state_d;
    logic [LOG2_N_STEPS-1:0] step_q,      step_d;
    logic [NB_TIMER-1:0]     timer_q,     timer_d;
    logic [NB_REPEAT-1:0]    sweep_q,     sweep_d;
    logic                    loop_q,      loop_d;
    logic [NB_REPEAT-1:0]    n_repeat_q,  n_repeat_d;
    logic [LOG2_N_STEPS-1:0] last_step_q, last_step_d;
    logic [N_STEPS-1:0]      pulse_bus_q, pulse_bus_d;
    logic                    busy_q,      busy_d;
    logic                    done_q,      done_d;

    logic [NB_TIMER-1:0]     limit_slot [N_SLOTS];
    logic [NB_TIMER-1:0]     cur_limit;
    logic [LOG2_N_STEPS-1:0] last_step_clamped;
    logic                    step_end;
    logic                    gap_on;
    logic                    gap_end;
    state_t                  after_step_state;
    step_action_t            step_action;
    logic [N_SLOTS-1:0]      onehot_d;

    // Slots beyond N_STEPS read as zero so any step index is a safe lookup.
    for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
        if (k < N_STEPS) begin : g_used
            assign limit_slot[k] = i_limit_time_bus[k*NB_TIMER +: NB_TIMER];
        end else begin : g_unused
            assign limit_slot[k] = '0;
        end
    end

    assign cur_limit         = limit_slot[step_q];
    assign last_step_clamped = ({1'b0, i_last_step} >= N_STEPS_EXT) ? LAST_MAX : i_last_step;

    // A zero-length step still occupies one cycle; >= keeps the timer bounded if L shrinks live.
    assign step_end = (cur_limit == '0) || (timer_q >= (cur_limit - TIMER_ONE));
    assign gap_on   = (i_gap_time != '0);
    assign gap_end  = !gap_on || (timer_q >= (i_gap_time - TIMER_ONE));

    assign after_step_state = gap_on ? ST_GAP : ST_STEP;

    always_comb begin
        if (step_q != last_step_q) begin
            step_action = ACT_NEXT_STEP;
        end else if (loop_q || (sweep_q != n_repeat_q)) begin
            step_action = ACT_NEXT_SWEEP;
        end else begin
            step_action = ACT_FINISH;
        end
    end

    always_comb begin
        // NOTE: every _d starts as its _q so no branch below can leave a signal unassigned and infer a latch.
        state_d     = state_q;
        step_d      = step_q;
        timer_d     = timer_q;
        sweep_d     = sweep_q;
        loop_d      = loop_q;
        n_repeat_d  = n_repeat_q;
        last_step_d = last_step_q;
        pulse_bus_d = pulse_bus_q;
        busy_d      = busy_q;
        done_d      = done_q;
        onehot_d    = '0;

        if (i_valid) begin
            if (i_abort) begin
                state_d = ST_IDLE;
                step_d  = '0;
                timer_d = '0;
                sweep_d = '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (i_trigger) begin
                            loop_d      = i_loop;
                            n_repeat_d  = i_n_repeat;
                            last_step_d = last_step_clamped;
                            step_d      = '0;
                            timer_d     = '0;
                            sweep_d     = '0;
                            state_d     = ST_STEP;
                        end
                    end
                    ST_STEP: begin
                        if (step_end) begin
                            timer_d = '0;
                            unique case (step_action)
                                ACT_NEXT_STEP: begin
                                    step_d  = step_q + STEP_ONE;
                                    state_d = after_step_state;
                                end
                                ACT_NEXT_SWEEP: begin
                                    sweep_d = sweep_q + SWEEP_ONE;
                                    step_d  = '0;
                                    state_d = after_step_state;
                                end
                                default: begin
                                    state_d = ST_DONE;
                                end
                            endcase
                        end else begin
                            timer_d = timer_q + TIMER_ONE;
                        end
                    end
                    ST_GAP: begin
                        if (gap_end) begin
                            timer_d = '0;
                            state_d = ST_STEP;
                        end else begin
                            timer_d = timer_q + TIMER_ONE;
                        end
                    end
                    ST_DONE: begin
                        state_d = ST_IDLE;
                        step_d  = '0;
                        timer_d = '0;
                        sweep_d = '0;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end

            // Outputs are decoded from the next state so they leave the flops with it.
            onehot_d    = ONEHOT_BASE << step_d;
            busy_d      = (state_d == ST_STEP) || (state_d == ST_GAP);
            done_d      = (state_d == ST_DONE);
            pulse_bus_d = '0;
            if ((state_d == ST_STEP) && (limit_slot[step_d] != '0)) begin
                pulse_bus_d = onehot_d[N_STEPS-1:0];
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            // NOTE: the latched configuration is reset with the state so no flop ever powers up unknown.
            state_q     <= ST_IDLE;
            step_q      <= '0;
            timer_q     <= '0;
            sweep_q     <= '0;
            loop_q      <= 1'b0;
            n_repeat_q  <= '0;
            last_step_q <= '0;
            pulse_bus_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
            state_q     <= state_d;
            step_q      <= step_d;
            timer_q     <= timer_d;
            sweep_q     <= sweep_d;
            loop_q      <= loop_d;
            n_repeat_q  <= n_repeat_d;
            last_step_q <= last_step_d;
            pulse_bus_q <= pulse_bus_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign o_pulse_bus = pulse_bus_q;
    assign o_step      = step_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_state     = NB_STATE'(state_q);

endmodule

// File: tb/tb_pulse_sequencer_multi.sv
// Self-checking bench for pulse_sequencer_multi: a directed cycle table, hand-written
// corner sequences, and randomized runs checked against a segment-expansion model.
module tb_pulse_sequencer_multi;

    localparam int N    = 4;
    localparam int LOG2 = 3;
    localparam int NBT  = 8;
    localparam int NBR  = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_STEP = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    typedef struct packed {
        logic [N-1:0]    pulse;
        logic [LOG2-1:0] step;
        logic            busy;
        logic            done;
        logic [1:0]      state;
    } exp_t;

    typedef struct packed {
        logic valid;
        logic trigger;
        logic abort;
        exp_t e;
    } vec_t;

    logic               i_clock = 1'b0;
    logic               i_reset = 1'b1;
    logic               i_valid = 1'b0;
    logic               i_trigger = 1'b0;
    logic               i_abort = 1'b0;
    logic               i_loop = 1'b0;
    logic [NBR-1:0]     i_n_repeat = '0;
    logic [LOG2-1:0]    i_last_step = '0;
    logic [N*NBT-1:0]   i_limit_time_bus = '0;
    logic [NBT-1:0]     i_gap_time = '0;
    logic [N-1:0]       o_pulse_bus;
    logic [LOG2-1:0]    o_step;
    logic               o_busy;
    logic               o_done;
    logic [1:0]         o_state;

    pulse_sequencer_multi #(
        .NB_STATE     (2),
        .N_STEPS      (N),
        .LOG2_N_STEPS (LOG2),
        .NB_TIMER     (NBT),
        .NB_REPEAT    (NBR)
    ) dut (
        .i_clock          (i_clock),
        .i_reset          (i_reset),
        .i_valid          (i_valid),
        .i_trigger        (i_trigger),
        .i_abort          (i_abort),
        .i_loop           (i_loop),
        .i_n_repeat       (i_n_repeat),
        .i_last_step      (i_last_step),
        .i_limit_time_bus (i_limit_time_bus),
        .i_gap_time       (i_gap_time),
        .o_pulse_bus      (o_pulse_bus),
        .o_step           (o_step),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_state          (o_state)
    );

    always #5 i_clock = ~i_clock;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cfg_lim [N];
    int   cfg_gap, cfg_last, cfg_rep;
    bit   cfg_loop;
    exp_t q [$];
    vec_t tv [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        check({tag, " pulse"}, 32'(o_pulse_bus), 32'(e.pulse));
        check({tag, " step"},  32'(o_step),      32'(e.step));
        check({tag, " busy"},  32'(o_busy),      32'(e.busy));
        check({tag, " done"},  32'(o_done),      32'(e.done));
        check({tag, " state"}, 32'(o_state),     32'(e.state));
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    function automatic exp_t mk(int p, int s, bit b, bit d, logic [1:0] st);
        exp_t e;
        e.pulse = N'(p);
        e.step  = LOG2'(s);
        e.busy  = b;
        e.done  = d;
        e.state = st;
        return e;
    endfunction

    function automatic vec_t mkv(bit v, bit t, bit a, exp_t e);
        vec_t r;
        r.valid   = v;
        r.trigger = t;
        r.abort   = a;
        r.e       = e;
        return r;
    endfunction

    task automatic drive_cfg();
        for (int k = 0; k < N; k++) i_limit_time_bus[k*NBT +: NBT] = NBT'(cfg_lim[k]);
        i_gap_time  = NBT'(cfg_gap);
        i_last_step = LOG2'(cfg_last);
        i_n_repeat  = NBR'(cfg_rep);
        i_loop      = cfg_loop;
    endtask

    // Reference: expand the run into one expected record per valid cycle.
    task automatic build_model();
        int last;
        int nsw;
        int nxt;
        last = (cfg_last > N - 1) ? N - 1 : cfg_last;
        nsw  = cfg_loop ? 64 : cfg_rep + 1;
        q.delete();
        for (int s = 0; s < nsw; s++) begin
            for (int k = 0; k <= last; k++) begin
                for (int t = 0; t < ((cfg_lim[k] == 0) ? 1 : cfg_lim[k]); t++)
                    q.push_back(mk((cfg_lim[k] != 0) ? (1 << k) : 0, k, 1'b1, 1'b0, S_STEP));
                if (!(s == nsw - 1 && k == last)) begin
                    nxt = (k == last) ? 0 : k + 1;
                    for (int g = 0; g < cfg_gap; g++) q.push_back(mk(0, nxt, 1'b1, 1'b0, S_GAP));
                end
            end
        end
        if (!cfg_loop) q.push_back(mk(0, last, 1'b0, 1'b1, S_DONE));
        q.push_back(mk(0, 0, 1'b0, 1'b0, S_IDLE));
    endtask

    // valid_mode: 0 always valid, 1 low every third cycle, 2 random.
    task automatic run(input string tag, input int valid_mode, input int abort_at, input bit hold_trig);
        exp_t cur;
        bit   v;
        bit   ab;
        int   c;
        build_model();
        drive_cfg();
        i_valid   = 1'b1;
        i_trigger = 1'b1;
        i_abort   = 1'b0;
        tick();
        cur = q.pop_front();
        c   = 1;
        forever begin
            ab = (c == abort_at);
            case (valid_mode)
                0:       v = 1'b1;
                1:       v = (c % 3) != 0;
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            if (ab) v = 1'b1;
            i_valid   = v;
            i_abort   = ab;
            i_trigger = hold_trig;
            check_out($sformatf("%s c%0d", tag, c), cur);
            if (cur.state == S_IDLE) break;
            if (c >= 3000) begin
                check({tag, " cycle budget"}, 32'(c), 32'(0));
                break;
            end
            tick();
            if (v) begin
                if (ab) begin
                    cur = mk(0, 0, 1'b0, 1'b0, S_IDLE);
                end else if (q.size() != 0) begin
                    cur = q.pop_front();
                end else begin
                    check({tag, " model exhausted"}, 32'(q.size()), 32'(1));
                    break;
                end
            end
            c++;
        end
        i_trigger = 1'b0;
        i_abort   = 1'b0;
        i_valid   = 1'b1;
    endtask

    initial begin
        // Directed table: limits {3,1,2,4}, gap 0, last 3, one-shot.
        tv[0] = mkv(1, 1, 0, mk(0, 0, 0, 0, S_IDLE));
        for (int c = 1; c <= 3; c++)  tv[c] = mkv(1, 0, 0, mk(1, 0, 1, 0, S_STEP));
        tv[4] = mkv(1, 0, 0, mk(2, 1, 1, 0, S_STEP));
        for (int c = 5; c <= 6; c++)  tv[c] = mkv(1, 0, 0, mk(4, 2, 1, 0, S_STEP));
        for (int c = 7; c <= 10; c++) tv[c] = mkv(1, 0, 0, mk(8, 3, 1, 0, S_STEP));
        tv[11] = mkv(1, 0, 0, mk(0, 3, 0, 1, S_DONE));
        tv[12] = mkv(1, 0, 0, mk(0, 0, 0, 0, S_IDLE));

        i_valid = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        check_out("reset", mk(0, 0, 1'b0, 1'b0, S_IDLE));

        cfg_lim = '{3, 1, 2, 4};
        cfg_gap = 0; cfg_last = 3; cfg_rep = 0; cfg_loop = 1'b0;
        drive_cfg();
        for (int i = 0; i < 13; i++) begin
            i_valid   = tv[i].valid;
            i_trigger = tv[i].trigger;
            i_abort   = tv[i].abort;
            check_out($sformatf("table c%0d", i), tv[i].e);
            tick();
        end
        i_trigger = 1'b0;

        cfg_lim = '{1, 1, 1, 1}; cfg_gap = 2; cfg_last = 1; cfg_rep = 0; cfg_loop = 1'b0;
        run("gap2", 0, -1, 1'b0);

        cfg_lim = '{2, 0, 1, 1}; cfg_gap = 0; cfg_last = 2;
        run("zero_len", 0, -1, 1'b0);

        cfg_lim = '{1, 1, 1, 1}; cfg_gap = 0; cfg_last = 1; cfg_rep = 2;
        run("repeat_hold_trig", 0, -1, 1'b1);

        cfg_lim = '{2, 2, 1, 1}; cfg_gap = 0; cfg_last = 1; cfg_rep = 0; cfg_loop = 1'b1;
        run("loop_abort", 1, 20, 1'b0);

        cfg_lim = '{1, 2, 1, 1}; cfg_gap = 1; cfg_last = 7; cfg_loop = 1'b0;
        run("clamp_last", 0, -1, 1'b0);

        // Reset in the middle of a gap, then a clean restart from step 0.
        cfg_lim = '{1, 1, 1, 1}; cfg_gap = 3; cfg_last = 3; cfg_rep = 0;
        drive_cfg();
        i_trigger = 1'b1;
        tick();
        i_trigger = 1'b0;
        tick();
        check("pre-reset gap state", 32'(o_state), 32'(S_GAP));
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check_out("mid-gap reset", mk(0, 0, 1'b0, 1'b0, S_IDLE));
        i_trigger = 1'b1;
        tick();
        i_trigger = 1'b0;
        check_out("restart", mk(1, 0, 1'b1, 1'b0, S_STEP));
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;

        for (int it = 0; it < 16; it++) begin
            int ab;
            for (int k = 0; k < N; k++) cfg_lim[k] = $urandom_range(0, 5);
            cfg_gap  = $urandom_range(0, 3);
            cfg_last = $urandom_range(0, 7);
            cfg_rep  = $urandom_range(0, 3);
            cfg_loop = ($urandom_range(0, 3) == 0);
            if (cfg_loop) ab = $urandom_range(3, 60);
            else ab = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 40) : -1;
            run($sformatf("rand%0d", it), 2, ab, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_sequencer_multi.md
# pulse_sequencer_multi

Parametrised successor of the single-sweep pulse sequencer. It steps a one-hot pulse bus through up to N_STEPS programmable-length steps, with these additions:
- a programmable idle gap between steps;
- a selectable last step;
- N repeated sweeps or a continuous loop;
- an abort input;
- busy and done status.

It sits in the control stack beside the GHASH/AES datapath. It sequences multi-cycle enables (load, multiply, reduce, flush) and routes its state to the stack for debug.

## Interface
- NB_STATE, 2: state register width; must be 2.
- N_STEPS, 8: number of steps and width of the pulse bus.
- LOG2_N_STEPS, 3: step index width; must satisfy 2^LOG2_N_STEPS >= N_STEPS.
- NB_TIMER, 8: width of each step-duration and gap counter.
- NB_REPEAT, 4: width of the sweep-repeat counter.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  reset; synchronous, active-high. Clock is i_clock.
- i_valid  in  1  clock enable. When low, all state, timers and outputs hold.
- i_trigger  in  1  start request; honoured only in ST_IDLE.
- i_abort  in  1  stop request; has priority over everything except i_reset.
- i_loop  in  1  1 = sweep until aborted; 0 = run i_n_repeat+1 sweeps.
- i_n_repeat  in  NB_REPEAT  number of extra sweeps.
- i_last_step  in  LOG2_N_STEPS  index of the last active step. Values >= N_STEPS clamp to N_STEPS-1.
- i_limit_time_bus  in  N_STEPS*NB_TIMER  per-step duration in valid cycles. Step k uses bits [k*NB_TIMER +: NB_TIMER].
- i_gap_time  in  NB_TIMER  idle valid cycles inserted between consecutive steps.
- o_pulse_bus  out  N_STEPS  one-hot; bit k is high while step k is active.
- o_step  out  LOG2_N_STEPS  current step index.
- o_busy  out  1  high in ST_STEP and ST_GAP.
- o_done  out  1  high for exactly one valid cycle at normal completion.
- o_state  out  NB_STATE  state register, routed to the stack.

## Operation
- States: ST_IDLE=0, ST_STEP=1, ST_GAP=2, ST_DONE=3.
- Reset values: state ST_IDLE, step 0, timer 0, sweep counter 0. Outputs: o_pulse_bus=0, o_step=0, o_busy=0, o_done=0, o_state=0.
- Transitions occur only on edges where i_valid=1.
- ST_IDLE:
  - If i_trigger: latch i_loop, i_n_repeat and the clamped i_last_step; clear step, timer and sweep counter; go to ST_STEP.
  - i_trigger is ignored in every other state.
- ST_STEP:
  - Timer counts valid cycles from 0.
  - The step ends when timer == L-1, where L is the live limit of the current step.
  - L=0 skips the step: it lasts one valid cycle and o_pulse_bus is all zero.
- At step end, the next action is taken in this order:
  - Not the last step: step+1. Go to ST_GAP if i_gap_time>0, otherwise directly to ST_STEP.
  - Last step, more sweeps pending (i_loop, or sweep counter != latched n_repeat): sweep counter +1 (wraps in loop mode), step 0, then ST_GAP or ST_STEP by the same gap rule.
  - Otherwise: go to ST_DONE.
- ST_GAP: lasts i_gap_time valid cycles, then ST_STEP. No gap is ever inserted before ST_DONE.
- ST_DONE: lasts one valid cycle with o_done=1, then ST_IDLE.
- i_abort with i_valid: go to ST_IDLE next edge from any state, clear counters, no o_done.
- Configuration lifetime: i_limit_time_bus and i_gap_time are read live (quasi-static). i_loop, i_n_repeat and i_last_step are latched at trigger only.
- Output decode:
  - o_pulse_bus = onehot(step) when state==ST_STEP and L!=0, else 0.
  - o_busy = (state==ST_STEP || state==ST_GAP).
  - All outputs are decoded from registers only; there is no combinational path from i_trigger or i_abort.

## Timing
- Start latency: trigger sampled at edge of cycle 0 → ST_STEP, step 0 pulse visible in cycle 1.
- Step k with L>0 occupies exactly L valid cycles; a gap occupies exactly i_gap_time valid cycles.
- Sweep length = Σ max(L_k,1) + last_step*gap.
- Total run length = (n_repeat+1) × sweep length + n_repeat×gap, plus 1 cycle in ST_DONE.
- Valid-low cycles stretch every interval without changing counts.
- Abort at edge n → o_pulse_bus=0 and o_busy=0 from cycle n+1.
- Reset mid-run → reset values next cycle.
- Timer and sweep counter never exceed their limits; there is no overflow with maximum durations 2^NB_TIMER-1.

## Test plan
- N_STEPS=4, limits {3,1,2,4} (step0 first), gap 0, last 3, one-shot, n_repeat 0, trigger at cycle 0 → bit0 cycles 1-3, bit1 cycle 4, bit2 cycles 5-6, bit3 cycles 7-10, o_done cycle 11, ST_IDLE cycle 12.
- Limits all 1, gap 2, last 1 → bit0 cycle 1, gap cycles 2-3, bit1 cycle 4, o_done cycle 5; o_busy high cycles 1-4.
- Limits {2,0,1}, last 2 → bit0 cycles 1-2, cycle 3 o_step=1 with pulse bus 0, bit2 cycle 4, o_done cycle 5.
- Limits {1,1}, last 1, n_repeat 2 → bits 0,1,0,1,0,1 cycles 1-6, o_done cycle 7. Trigger held high during the run is ignored.
- Loop mode, limits {2,2}, i_valid low every third cycle → pulse stretched by the frozen cycles. Abort at cycle 20 → outputs 0 at cycle 21, o_done never asserted.
- i_last_step=7 with N_STEPS=4 clamps to step 3. Reset asserted during ST_GAP → all outputs 0 next cycle, new trigger restarts at step 0.
